// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REGIDX_WIDTH = 5;

  // Arbitration modes.
  localparam int ARB_RR       = 0;
  localparam int ARB_LSU_PRIO = 1;

  // Bit positions in the grant vector.
  localparam int GNT_ALU = 0;
  localparam int GNT_LSU = 1;

  typedef enum logic {WB_SRC_ALU, WB_SRC_LSU} wb_src_e;

  // Contents of the registered regfile write port.
  typedef struct packed {
    logic                    wen;
    logic [REGIDX_WIDTH-1:0] addr;
    logic [31:0]             data;
    wb_src_e                 src;
  } wb_port_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two valid/ready sources in, one regfile write port out.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                    i_alu_valid;
  logic                    o_alu_ready;
  logic [REGIDX_WIDTH-1:0] i_alu_rd_addr;
  logic [31:0]             i_alu_rd_data;

  logic                    i_lsu_valid;
  logic                    o_lsu_ready;
  logic [REGIDX_WIDTH-1:0] i_lsu_rd_addr;
  logic [31:0]             i_lsu_rd_data;

  logic                    o_rd_wen;
  logic [REGIDX_WIDTH-1:0] o_rd_addr;
  logic [31:0]             o_rd_data;
  wb_src_e                 o_wb_src;
  logic [3:0]              o_alu_wait_cnt;

  // Source/regfile side.
  modport master (
    output i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    output i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    input  o_alu_ready, o_lsu_ready,
    input  o_rd_wen, o_rd_addr, o_rd_data, o_wb_src, o_alu_wait_cnt
  );

  // Arbiter side.
  modport slave (
    input  i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    input  i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    output o_alu_ready, o_lsu_ready,
    output o_rd_wen, o_rd_addr, o_rd_data, o_wb_src, o_alu_wait_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_grant.sv
// Grant logic: round-robin pointer, ALU aging counter and the
// combinational one-hot grant vector.
module wb_arb_grant
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_alu_valid,
  input  logic       i_lsu_valid,
  output logic [1:0] o_grant,
  output logic [3:0] o_alu_wait_cnt
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  wb_src_e    rr_ptr, rr_ptr_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       alu_win, lsu_win;

  // Pick the winner; a lone requester always wins, nothing wins in reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    alu_win = 1'b0;
    lsu_win = 1'b0;
    if (i_alu_valid && i_lsu_valid) begin
      if (ARB_MODE == ARB_LSU_PRIO) alu_win = (wait_cnt == MAX_WAIT_C);
      else                          alu_win = (rr_ptr == WB_SRC_ALU);
      lsu_win = !alu_win;
    end else begin
      alu_win = i_alu_valid;
      lsu_win = i_lsu_valid;
    end
    // Reset kills any grant so a request presented during reset is not consumed.
    o_grant[GNT_ALU] = alu_win && i_rst_n;
    o_grant[GNT_LSU] = lsu_win && i_rst_n;
  end

  // Next pointer and aging count from this cycle's contention outcome.
  always_comb begin
    rr_ptr_nxt   = rr_ptr;
    wait_cnt_nxt = 4'd0;
    if (ARB_MODE == ARB_RR && i_alu_valid && i_lsu_valid)
      rr_ptr_nxt = alu_win ? WB_SRC_LSU : WB_SRC_ALU;
    if (ARB_MODE == ARB_LSU_PRIO && i_alu_valid && !alu_win)
      wait_cnt_nxt = (wait_cnt == MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt + 4'd1;
  end

  // Arbitration state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr   <= WB_SRC_ALU;
      wait_cnt <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rr_ptr   <= rr_ptr_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign o_alu_wait_cnt = wait_cnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the ALU and LSU writeback sources onto the single regfile
// write port through a one-stage registered write port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int MAX_WAIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic [1:0] grant;
  logic [3:0] alu_wait_cnt;
  wb_port_t   wp_q, wp_nxt;

  wb_arb_grant #(
    .ARB_MODE (ARB_MODE),
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_alu_valid    (bus.i_alu_valid),
    .i_lsu_valid    (bus.i_lsu_valid),
    .o_grant        (grant),
    .o_alu_wait_cnt (alu_wait_cnt)
  );

  assign bus.o_alu_ready    = grant[GNT_ALU];
  assign bus.o_lsu_ready    = grant[GNT_LSU];
  assign bus.o_alu_wait_cnt = alu_wait_cnt;

  // Mux the winner into the write port; x0 handshakes but never writes.
  always_comb begin
    wp_nxt     = wp_q;
    wp_nxt.wen = 1'b0;
    if (grant[GNT_ALU]) begin
      wp_nxt.wen  = |bus.i_alu_rd_addr;
      wp_nxt.addr = bus.i_alu_rd_addr;
      wp_nxt.data = bus.i_alu_rd_data;
      wp_nxt.src  = WB_SRC_ALU;
    end else if (grant[GNT_LSU]) begin
      wp_nxt.wen  = |bus.i_lsu_rd_addr;
      wp_nxt.addr = bus.i_lsu_rd_addr;
      wp_nxt.data = bus.i_lsu_rd_data;
      wp_nxt.src  = WB_SRC_LSU;
    end
  end

  // Write-port register driving the regfile directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp_q <= '{wen: 1'b0, addr: '0, data: '0, src: WB_SRC_ALU};
    end else begin
      wp_q <= wp_nxt;
    end
  end

  assign bus.o_rd_wen  = wp_q.wen;
  assign bus.o_rd_addr = wp_q.addr;
  assign bus.o_rd_data = wp_q.data;
  assign bus.o_wb_src  = wp_q.src;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: one round-robin and one LSU-priority
// instance, with expected write-port contents queued at grant time and
// compared after the following edge.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;

  typedef struct {
    bit          load;
    bit          wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus_rr ();
  regfile_wb_arbiter_if bus_pr ();

  regfile_wb_arbiter #(.ARB_MODE(ARB_RR), .MAX_WAIT(MAX_WAIT)) dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_rr)
  );

  regfile_wb_arbiter #(.ARB_MODE(ARB_LSU_PRIO), .MAX_WAIT(MAX_WAIT)) dut_pr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_pr)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_rr[$];
  exp_t q_pr[$];
  bit   m_ptr_lsu;   // round-robin model: 1 = LSU preferred
  int   m_cnt;       // aging model
  bit   g_rr_ga, g_rr_gl, g_pr_ga, g_pr_gl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(bit rst_act, bit ga, bit gl,
                                  logic [4:0] aa, logic [31:0] ad,
                                  logic [4:0] la, logic [31:0] ld);
    exp_t e;
    e = '{load: 1'b0, wen: 1'b0, addr: 5'd0, data: 32'd0, src: 1'b0};
    if (rst_act)  e.load = 1'b1;
    else if (ga)  e = '{load: 1'b1, wen: (aa != 5'd0), addr: aa, data: ad, src: 1'b0};
    else if (gl)  e = '{load: 1'b1, wen: (la != 5'd0), addr: la, data: ld, src: 1'b1};
    return e;
  endfunction

  task automatic cmp_port(input string pfx, input exp_t e, input logic wen,
                          input logic [4:0] addr, input logic [31:0] data, input logic src);
    check({pfx, "_wen"}, wen, e.wen);
    if (e.load) begin
      check({pfx, "_addr"}, addr, e.addr);
      check({pfx, "_data"}, data, e.data);
      check({pfx, "_src"},  src,  e.src);
    end
  endtask

  // One clock: check readies mid-cycle, queue the expected write, compare after the edge.
  task automatic tick();
    bit a, l, ga, gl;
    exp_t e;
    @(negedge clk);
    // round-robin instance
    a = bus_rr.i_alu_valid; l = bus_rr.i_lsu_valid; ga = 0; gl = 0;
    if (!rst_n) m_ptr_lsu = 0;
    else if (a && l) begin ga = !m_ptr_lsu; gl = m_ptr_lsu; m_ptr_lsu = !m_ptr_lsu; end
    else begin ga = a; gl = l; end
    check("rr_alu_ready", bus_rr.o_alu_ready, ga);
    check("rr_lsu_ready", bus_rr.o_lsu_ready, gl);
    q_rr.push_back(mk_exp(!rst_n, ga, gl, bus_rr.i_alu_rd_addr, bus_rr.i_alu_rd_data,
                          bus_rr.i_lsu_rd_addr, bus_rr.i_lsu_rd_data));
    g_rr_ga = ga; g_rr_gl = gl;
    // LSU-priority instance
    a = bus_pr.i_alu_valid; l = bus_pr.i_lsu_valid; ga = 0; gl = 0;
    if (rst_n) begin
      if (a && l) begin ga = (m_cnt == MAX_WAIT); gl = !ga; end
      else begin ga = a; gl = l; end
    end
    check("pr_alu_ready", bus_pr.o_alu_ready, ga);
    check("pr_lsu_ready", bus_pr.o_lsu_ready, gl);
    q_pr.push_back(mk_exp(!rst_n, ga, gl, bus_pr.i_alu_rd_addr, bus_pr.i_alu_rd_data,
                          bus_pr.i_lsu_rd_addr, bus_pr.i_lsu_rd_data));
    if (!rst_n)        m_cnt = 0;
    else if (a && !ga) m_cnt = (m_cnt == MAX_WAIT) ? MAX_WAIT : m_cnt + 1;
    else               m_cnt = 0;
    g_pr_ga = ga; g_pr_gl = gl;
    @(posedge clk);
    #1;
    e = q_rr.pop_front();
    cmp_port("rr", e, bus_rr.o_rd_wen, bus_rr.o_rd_addr, bus_rr.o_rd_data, bus_rr.o_wb_src);
    e = q_pr.pop_front();
    cmp_port("pr", e, bus_pr.o_rd_wen, bus_pr.o_rd_addr, bus_pr.o_rd_data, bus_pr.o_wb_src);
    check("pr_wait_cnt", bus_pr.o_alu_wait_cnt, m_cnt);
    check("rr_wait_cnt", bus_rr.o_alu_wait_cnt, 0);
  endtask

  task automatic idle_all();
    bus_rr.i_alu_valid = 0; bus_rr.i_alu_rd_addr = '0; bus_rr.i_alu_rd_data = '0;
    bus_rr.i_lsu_valid = 0; bus_rr.i_lsu_rd_addr = '0; bus_rr.i_lsu_rd_data = '0;
    bus_pr.i_alu_valid = 0; bus_pr.i_alu_rd_addr = '0; bus_pr.i_alu_rd_data = '0;
    bus_pr.i_lsu_valid = 0; bus_pr.i_lsu_rd_addr = '0; bus_pr.i_lsu_rd_data = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         rr_alu_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] cnt_seq    [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    rst_n = 1'b0;
    m_ptr_lsu = 0;
    m_cnt = 0;
    idle_all();

    // 1: reset with both valids high on both instances
    bus_rr.i_alu_valid = 1; bus_rr.i_alu_rd_addr = 5'd5; bus_rr.i_alu_rd_data = 32'hAAAA_0001;
    bus_rr.i_lsu_valid = 1; bus_rr.i_lsu_rd_addr = 5'd6; bus_rr.i_lsu_rd_data = 32'h5555_0002;
    bus_pr.i_alu_valid = 1; bus_pr.i_alu_rd_addr = 5'd5; bus_pr.i_alu_rd_data = 32'hAAAA_0001;
    bus_pr.i_lsu_valid = 1; bus_pr.i_lsu_rd_addr = 5'd6; bus_pr.i_lsu_rd_data = 32'h5555_0002;
    tick();
    tick();
    rst_n = 1'b1;
    bus_pr.i_alu_valid = 0;
    bus_pr.i_lsu_valid = 0;

    // 2: round-robin contention, each source advancing after its grant
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_grant_order", g_rr_ga, rr_alu_pat[i]);
      if (g_rr_ga) bus_rr.i_alu_rd_data = bus_rr.i_alu_rd_data + 32'd16;
      if (g_rr_gl) bus_rr.i_lsu_rd_data = bus_rr.i_lsu_rd_data + 32'd16;
    end
    idle_all();

    // 3: LSU priority with ALU aging
    bus_pr.i_alu_valid = 1; bus_pr.i_alu_rd_addr = 5'd7; bus_pr.i_alu_rd_data = 32'h0A0A_0007;
    bus_pr.i_lsu_valid = 1; bus_pr.i_lsu_rd_addr = 5'd8; bus_pr.i_lsu_rd_data = 32'h0B0B_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pr_cnt_seq", bus_pr.o_alu_wait_cnt, cnt_seq[i]);
      if (g_pr_gl) bus_pr.i_lsu_rd_data = bus_pr.i_lsu_rd_data + 32'd1;
      if (g_pr_ga) bus_pr.i_alu_valid = 0;
    end
    tick();
    idle_all();

    // 4: load return to x0 handshakes but does not write
    bus_rr.i_lsu_valid = 1; bus_rr.i_lsu_rd_addr = 5'd0; bus_rr.i_lsu_rd_data = 32'hDEAD_BEEF;
    tick();
    check("x0_no_write", bus_rr.o_rd_wen, 1'b0);
    idle_all();

    // 5: ALU alone, three back-to-back writes to x31; PR instance builds up aging
    bus_rr.i_alu_valid = 1; bus_rr.i_alu_rd_addr = 5'd31; bus_rr.i_alu_rd_data = 32'h1234_5678;
    bus_pr.i_alu_valid = 1; bus_pr.i_alu_rd_addr = 5'd9;  bus_pr.i_alu_rd_data = 32'h0000_0009;
    bus_pr.i_lsu_valid = 1; bus_pr.i_lsu_rd_addr = 5'd10; bus_pr.i_lsu_rd_data = 32'h0000_000A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_wen", bus_rr.o_rd_wen, 1'b1);
    end

    // 6: asynchronous reset mid-cycle while a write is on the port
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wen",       bus_rr.o_rd_wen,       1'b0);
    check("arst_addr",      bus_rr.o_rd_addr,      5'd0);
    check("arst_data",      bus_rr.o_rd_data,      32'd0);
    check("arst_src",       bus_rr.o_wb_src,       WB_SRC_ALU);
    check("arst_alu_ready", bus_rr.o_alu_ready,    1'b0);
    check("arst_pr_cnt",    bus_pr.o_alu_wait_cnt, 4'd0);
    check("arst_pr_wen",    bus_pr.o_rd_wen,       1'b0);
    m_ptr_lsu = 0;
    m_cnt = 0;
    idle_all();
    #3;
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", bus_pr.o_alu_wait_cnt, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
